// File: rtl/alu_operand_stage.sv
// alu_operand_stage: one-entry operand latch with bypass resolution feeding the CLA adder.
// Optional feature macro: ALU_OPERAND_FWD_EN enables bypass selects and the load-use bubble.
module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 17
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic             in_use_imm,
  input  logic [WIDTH-1:0] in_rs_data,
  input  logic [WIDTH-1:0] in_rt_data,
  input  logic [IMM_W-1:0] in_imm,
  input  logic [1:0]       in_fwd_a,
  input  logic [1:0]       in_fwd_b,
  input  logic [WIDTH-1:0] exm_data,
  input  logic             exm_is_load,
  input  logic [WIDTH-1:0] mw_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] input_a,
  output logic [WIDTH-1:0] input_b,
  output logic             c_in
);
  typedef enum logic [1:0] {EMPTY = 2'd0, HOLD = 2'd1, BUBBLE = 2'd2} state_t;
  state_t state, state_n;
  logic sub, use_imm, cap, hazard;
  logic [WIDTH-1:0] rs, rt, imm_ext, a, b_raw;
  logic [1:0] fwd_a, fwd_b, fa_in, fb_in;
`ifdef ALU_OPERAND_FWD_EN
  // Reserved select 11 is folded to the register file at capture time.
  assign fa_in = &in_fwd_a ? 2'b00 : in_fwd_a;
  assign fb_in = &in_fwd_b ? 2'b00 : in_fwd_b;
  assign hazard = exm_is_load & (fa_in == 2'b01 | (fb_in == 2'b01 & ~in_use_imm));
`else
  logic unused_fwd;
  assign unused_fwd = ^{in_fwd_a, in_fwd_b, exm_is_load};
  assign fa_in = 2'b00;
  assign fb_in = 2'b00;
  assign hazard = 1'b0;
`endif
  assign out_valid = state == HOLD;
  assign in_ready = state == EMPTY | (out_valid & out_ready);
  assign cap = in_valid & in_ready;
  always_comb begin
    state_n = flush ? EMPTY :
              cap ? (hazard ? BUBBLE : HOLD) :
              state == BUBBLE ? HOLD :
              (out_valid & out_ready) ? EMPTY : state;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      sub <= 1'b0;
      use_imm <= 1'b0;
      rs <= '0;
      rt <= '0;
      imm_ext <= '0;
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else begin
      state <= state_n;
      if (cap & ~flush) begin
        sub <= in_sub;
        use_imm <= in_use_imm;
        rs <= in_rs_data;
        rt <= in_rt_data;
        imm_ext <= {{(WIDTH-IMM_W){in_imm[IMM_W-1]}}, in_imm};
        fwd_a <= fa_in;
        fwd_b <= fb_in;
      end else if (state == BUBBLE) begin
        // The load has moved on to MEM/WB during the bubble.
        fwd_a <= fwd_a == 2'b01 ? 2'b10 : fwd_a;
        fwd_b <= fwd_b == 2'b01 ? 2'b10 : fwd_b;
      end
    end
  end
  always_comb begin
    a = fwd_a == 2'b01 ? exm_data : fwd_a == 2'b10 ? mw_data : rs;
    b_raw = use_imm ? imm_ext : fwd_b == 2'b01 ? exm_data : fwd_b == 2'b10 ? mw_data : rt;
  end
  assign input_a = out_valid ? a : '0;
  assign input_b = out_valid ? (sub ? ~b_raw : b_raw) : '0;
  assign c_in = out_valid & sub;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: vector table, randomized model checks and hand sequences for alu_operand_stage.
module tb_alu_operand_stage;
`ifdef ALU_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clock = 1'b0, reset_n = 1'b0, in_valid = 1'b0, in_ready, in_sub = 1'b0, in_use_imm = 1'b0;
  logic [31:0] in_rs_data = '0, in_rt_data = '0, exm_data = '0, mw_data = '0, input_a, input_b;
  logic [16:0] in_imm = '0;
  logic [1:0] in_fwd_a = '0, in_fwd_b = '0;
  logic exm_is_load = 1'b0, flush = 1'b0, out_valid, out_ready = 1'b1, c_in;
  int checks = 0, failures = 0;

  alu_operand_stage dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sub(in_sub), .in_use_imm(in_use_imm), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_fwd_a(in_fwd_a), .in_fwd_b(in_fwd_b), .exm_data(exm_data),
    .exm_is_load(exm_is_load), .mw_data(mw_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .input_a(input_a), .input_b(input_b), .c_in(c_in)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic sub, use_imm;
    logic [31:0] rs, rt;
    logic [16:0] imm;
    logic [1:0] fa, fb;
    logic [31:0] exm, mw, ea, eb;
    logic ec;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic s, input logic ui, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [16:0] im, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] ex, input logic [31:0] mw);
    in_sub = s; in_use_imm = ui; in_rs_data = rs; in_rt_data = rt; in_imm = im;
    in_fwd_a = fa; in_fwd_b = fb; exm_data = ex; mw_data = mw;
  endtask

  // Capture one instruction from EMPTY, then stop at the middle of the presentation cycle.
  task automatic issue(input logic s, input logic ui, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [16:0] im, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] ex, input logic [31:0] mw);
    drive(s, ui, rs, rt, im, fa, fb, ex, mw);
    in_valid = 1'b1;
    exm_is_load = 1'b0;
    tick();
    in_valid = 1'b0;
    @(negedge clock);
  endtask

  function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] r,
                                       input logic [31:0] e, input logic [31:0] m);
    if (!FWD) return r;
    return f == 2'd1 ? e : f == 2'd2 ? m : r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'h5, 32'h3, 17'h0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h5, 32'hFFFF_FFFC, 1'b1};
    vt[1] = '{1'b0, 1'b0, 32'h5, 32'h3, 17'h0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h5, 32'h3, 1'b0};
    vt[2] = '{1'b0, 1'b1, 32'h10, 32'h0, 17'h1FFFF, 2'd0, 2'd0, 32'h0, 32'h0, 32'h10, 32'hFFFF_FFFF, 1'b0};
    vt[3] = '{1'b1, 1'b1, 32'h0, 32'h0, 17'h0FFFF, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_0000, 1'b1};
    vt[4] = '{1'b0, 1'b0, 32'h7, 32'h1, 17'h0, 2'd1, 2'd0, 32'h1234, 32'h0, FWD ? 32'h1234 : 32'h7, 32'h1, 1'b0};
    vt[5] = '{1'b0, 1'b0, 32'h0, 32'h9, 17'h0, 2'd0, 2'd2, 32'h0, 32'hBEEF, 32'h0, FWD ? 32'hBEEF : 32'h9, 1'b0};
    vt[6] = '{1'b0, 1'b0, 32'hAAAA_5555, 32'h2, 17'h0, 2'd3, 2'd3, 32'hDEAD, 32'hBEEF, 32'hAAAA_5555, 32'h2, 1'b0};
    vt[7] = '{1'b0, 1'b1, 32'h1, 32'h2, 17'h5, 2'd0, 2'd1, 32'hCAFE, 32'h0, 32'h1, 32'h5, 1'b0};
    vt[8] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 17'h0, 2'd0, 2'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    vt[9] = '{1'b0, 1'b1, 32'h0, 32'h0, 17'h10000, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_0000, 1'b0};

    #2;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk("rst_input_a", input_a, 32'h0);
    chk("rst_input_b", input_b, 32'h0);
    chk1("rst_c_in", c_in, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    @(negedge clock);
    chk1("post_rst_out_valid", out_valid, 1'b0);
    chk1("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_input_b", input_b, 32'h0);

    for (int i = 0; i < 10; i++) begin
      issue(vt[i].sub, vt[i].use_imm, vt[i].rs, vt[i].rt, vt[i].imm, vt[i].fa, vt[i].fb, vt[i].exm, vt[i].mw);
      chk1($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_a", i), input_a, vt[i].ea);
      chk($sformatf("vec%0d_b", i), input_b, vt[i].eb);
      chk1($sformatf("vec%0d_cin", i), c_in, vt[i].ec);
      tick();
    end

    for (int i = 0; i < 40; i++) begin
      logic s, ui;
      logic [1:0] fa, fb;
      logic [16:0] im;
      logic [31:0] rs, rt, ex, mw, ea, eb, sx;
      s = 1'($urandom); ui = 1'($urandom); fa = 2'($urandom); fb = 2'($urandom);
      im = 17'($urandom); rs = $urandom; rt = $urandom; ex = $urandom; mw = $urandom;
      sx = {15'b0, im} - (im[16] ? 32'h2_0000 : 32'h0);
      ea = pick(fa, rs, ex, mw);
      eb = ui ? sx : pick(fb, rt, ex, mw);
      issue(s, ui, rs, rt, im, fa, fb, ex, mw);
      chk1("rnd_valid", out_valid, 1'b1);
      chk("rnd_a", input_a, ea);
      chk1("rnd_cin", c_in, s);
      chk("rnd_sum", input_a + input_b + {31'b0, c_in}, s ? ea - eb : ea + eb);
      tick();
    end

    drive(1'b0, 1'b0, 32'h77, 32'h0, 17'h0, 2'd1, 2'd0, 32'h5, 32'h0);
    in_valid = 1'b1;
    exm_is_load = 1'b1;
    tick();
    in_valid = 1'b0;
    exm_is_load = 1'b0;
    mw_data = 32'hBEEF;
    @(negedge clock);
    if (FWD) begin
      chk1("lu_bubble_valid", out_valid, 1'b0);
      chk1("lu_bubble_ready", in_ready, 1'b0);
      chk("lu_bubble_a", input_a, 32'h0);
      tick();
      @(negedge clock);
      chk1("lu_valid", out_valid, 1'b1);
      chk("lu_a", input_a, 32'hBEEF);
    end else begin
      chk1("lu_nofwd_valid", out_valid, 1'b1);
      chk("lu_nofwd_a", input_a, 32'h77);
    end
    tick();

    drive(1'b0, 1'b1, 32'h1, 32'h2, 17'h9, 2'd0, 2'd1, 32'h3, 32'h4);
    in_valid = 1'b1;
    exm_is_load = 1'b1;
    tick();
    in_valid = 1'b0;
    exm_is_load = 1'b0;
    @(negedge clock);
    chk1("lu_imm_no_bubble", out_valid, 1'b1);
    chk("lu_imm_b", input_b, 32'h9);
    tick();

    issue(1'b0, 1'b0, 32'h11, 32'h22, 17'h0, 2'd0, 2'd0, 32'h0, 32'h0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_valid", out_valid, 1'b1);
      chk("bp_a", input_a, 32'h11);
      chk("bp_b", input_b, 32'h22);
      tick();
    end
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h33, 32'h1, 17'h0, 2'd0, 2'd0, 32'h0, 32'h0);
    in_valid = 1'b1;
    @(negedge clock);
    chk1("handoff_in_ready", in_ready, 1'b1);
    chk("handoff_old_a", input_a, 32'h11);
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    chk1("handoff_valid", out_valid, 1'b1);
    chk("handoff_a", input_a, 32'h33);
    chk("handoff_b", input_b, 32'hFFFF_FFFE);
    tick();
    @(negedge clock);
    chk1("drain_valid", out_valid, 1'b0);

    drive(1'b0, 1'b0, 32'h44, 32'h0, 17'h0, 2'd0, 2'd0, 32'h0, 32'h0);
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clock);
    chk1("flush_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clock);
    chk1("flush_cap_valid", out_valid, 1'b0);
    chk("flush_cap_a", input_a, 32'h0);

    issue(1'b0, 1'b0, 32'h55, 32'h0, 17'h0, 2'd0, 2'd0, 32'h0, 32'h0);
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clock);
    chk1("flush_hold_valid", out_valid, 1'b0);
    chk1("flush_hold_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    issue(1'b1, 1'b0, 32'h66, 32'h1, 17'h0, 2'd0, 2'd0, 32'h0, 32'h0);
    out_ready = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk1("async_rst_valid", out_valid, 1'b0);
    chk1("async_rst_ready", in_ready, 1'b1);
    chk1("async_rst_cin", c_in, 1'b0);
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    chk1("async_rst_lost", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Execute-stage operand latch that sits directly upstream of the 32-bit CLA ALU adder. Captures decoded instructions from decode through a one-entry valid/ready register, resolves bypassing from the EX/MEM and MEM/WB stages, and drives the adder's `input_a`, `input_b` and `c_in`. Subtraction is formed as `a + ~b + 1`. A load-use hazard inserts exactly one bubble before the dependent instruction is presented.

## Interface
- `WIDTH`, default 32: datapath width; must equal the adder width.
- `IMM_W`, default 17: immediate field width, sign-extended to `WIDTH`.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage accepts the instruction this cycle.
- `in_sub` in 1: 1 = subtract, 0 = add.
- `in_use_imm` in 1: the B operand is the sign-extended immediate.
- `in_rs_data` in WIDTH: register-file A value.
- `in_rt_data` in WIDTH: register-file B value.
- `in_imm` in IMM_W: immediate field.
- `in_fwd_a`, `in_fwd_b` in 2: bypass select. 00 = register file, 01 = EX/MEM, 10 = MEM/WB, 11 = reserved (treated as 00).
- `exm_data` in WIDTH: live EX/MEM result.
- `exm_is_load` in 1: the EX/MEM instruction is a load whose data is not yet available.
- `mw_data` in WIDTH: live MEM/WB write-back value.
- `flush` in 1: squash the held instruction (branch or exception).
- `out_valid` out 1: the adder operands are valid this cycle.
- `out_ready` in 1: the downstream EX/MEM latch accepts.
- `input_a`, `input_b` out WIDTH: operands to the adder.
- `c_in` out 1: carry-in to the adder.

## Operation
- The register holds `sub`, `use_imm`, `rs`, `rt`, `imm_ext`, `fwd_a`, `fwd_b`, and the state.
- States:
  - EMPTY: nothing held.
  - HOLD: an instruction is held and presented.
  - BUBBLE: an instruction is held and waiting one cycle on a load.
- `in_ready` = (state == EMPTY) | (state == HOLD & out_ready & out_valid). Capture occurs when `in_valid & in_ready`.
- Transitions:
  - On capture, the next state is BUBBLE if (`fwd_a` == 01 or (`fwd_b` == 01 and !`use_imm`)) and `exm_is_load`, sampled in the capture cycle. Otherwise the next state is HOLD.
  - BUBBLE → HOLD unconditionally after one cycle. The selects that pointed at EX/MEM are rewritten to 10 (MEM/WB), because the load has advanced.
  - HOLD with `out_ready` and no capture → EMPTY.
- `out_valid` = (state == HOLD).
- Operand resolution (combinational from the held fields and the live bypass buses):
  - A = mux(`fwd_a`: `rs`, `exm_data`, `mw_data`).
  - Braw = `use_imm` ? `imm_ext` : mux(`fwd_b`: `rt`, `exm_data`, `mw_data`).
- Adder drive:
  - `input_a` = A.
  - `input_b` = `sub` ? ~Braw : Braw.
  - `c_in` = `sub`.
- Immediates are sign-extended from bit IMM_W−1. All arithmetic is modulo 2^WIDTH; overflow detection belongs to the adder.
- `flush` takes priority over everything: the next state is EMPTY and any capture in the same cycle is discarded. `in_ready` is still computed normally, so decode sees the instruction as consumed and squashed.
- Whenever `out_valid` = 0, the outputs `input_a`, `input_b` and `c_in` are forced to 0.

## Timing
- Reset (asynchronous, `reset_n` low): state = EMPTY and all held fields = 0. Outputs: `out_valid` = 0, `in_ready` = 1, `input_a` = 0, `input_b` = 0, `c_in` = 0.
- Latency, no hazard: an instruction captured at edge N is presented with `out_valid` = 1 during cycle N+1.
- Latency, load-use: the instruction is presented during cycle N+2.
- Back-to-back throughput is one instruction per cycle while `out_ready` = 1.
- With `out_ready` = 0 in HOLD, the held fields stay stable and `in_ready` = 0. The operands may still change if the bypass buses change; the downstream latch samples only when `out_ready` = 1.
- Reset asserted mid-BUBBLE or mid-HOLD: the state returns to EMPTY immediately and the instruction is lost.

## Configuration
- `ALU_OPERAND_FWD_EN`:
  - Defined: bypass selects and the load-use BUBBLE behave as specified above.
  - Undefined: `in_fwd_a` and `in_fwd_b` are ignored and treated as 00, BUBBLE is never entered, and `exm_data`, `mw_data` and `exm_is_load` are unused. Hazards are then the compiler's responsibility.

## Test plan
- Reset: hold `reset_n` = 0 and then release it → `out_valid` = 0, `in_ready` = 1, all operand outputs 0.
- Add/sub:
  - Capture `rs` = 0x0000_0005, `rt` = 0x0000_0003, `sub` = 1 → the next cycle shows `input_a` = 0x5, `input_b` = 0xFFFF_FFFC, `c_in` = 1.
  - The same with `sub` = 0 → `input_b` = 0x3, `c_in` = 0.
- Immediate: `use_imm` = 1, `in_imm` = 17'h1FFFF, `sub` = 0 → `input_b` = 0xFFFF_FFFF.
- Bypass (with `ALU_OPERAND_FWD_EN` defined):
  - `fwd_a` = 01, `exm_data` = 0x1234, `exm_is_load` = 0 → `input_a` = 0x1234 one cycle after capture.
  - With `exm_is_load` = 1 and `mw_data` = 0xBEEF on the following cycle → `out_valid` = 0 for one cycle, then `input_a` = 0xBEEF with `out_valid` = 1.
- Backpressure and flush:
  - `out_ready` = 0 for 3 cycles → `in_ready` = 0 and the held operands stay constant. Then `out_ready` = 1 with a new `in_valid` → hand-off happens in the same cycle with no gap.
  - Assert `flush` together with `in_valid` → `out_valid` = 0 on the next cycle.
